// File: rtl/food_placer_if.sv
// Signal bundle between the food placer and the rest of the snake game.
// The game side (master) drives candidates, body map and head; the placer (slave) returns food state.
interface food_placer_if #(
    parameter int SCORE_W = 8
);
    logic [7:0]         cand_a;
    logic [7:0]         cand_b;
    logic [99:0]        body_map;
    logic [7:0]         head_pos;
    logic               move_tick;
    logic [7:0]         food_pos;
    logic               food_valid;
    logic               eaten;
    logic [SCORE_W-1:0] score;
    logic               board_full;

    modport master (
        output cand_a, cand_b, body_map, head_pos, move_tick,
        input  food_pos, food_valid, eaten, score, board_full
    );

    modport slave (
        input  cand_a, cand_b, body_map, head_pos, move_tick,
        output food_pos, food_valid, eaten, score, board_full
    );
endinterface

// File: rtl/food_placer.sv
// Food placement for the snake game: accepts free candidate cells, falls back to a
// linear scan after repeated misses, and tracks eating and score.
module food_placer #(
    parameter int MAX_TRIES = 16,
    parameter int SCORE_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    food_placer_if.slave  bus
);

    localparam logic [7:0] TRIES_LAST = 8'(MAX_TRIES - 1);
    localparam logic [7:0] SCAN_FIRST = 8'd12;
    localparam logic [7:0] SCAN_LAST  = 8'd89;

    typedef enum logic [2:0] {
        SAMPLE,
        CHECK,
        SCAN,
        HOLD,
        FULL
    } state_t;

    state_t             state_reg,      state_next;
    logic [7:0]         cand_a_reg,     cand_a_next;
    logic [7:0]         cand_b_reg,     cand_b_next;
    logic [7:0]         tries_reg,      tries_next;
    logic [7:0]         scan_idx_reg,   scan_idx_next;
    logic [7:0]         food_pos_reg,   food_pos_next;
    logic               food_valid_reg, food_valid_next;
    logic               eaten_reg,      eaten_next;
    logic [SCORE_W-1:0] score_reg,      score_next;
    logic               board_full_reg, board_full_next;

    // Free-cell vector: playable mask is a constant, so off-field cells never look at body_map.
    logic [99:0]  free_vec;
    logic [127:0] free_ext;

    for (genvar gi = 0; gi < 100; gi++) begin : g_free
        localparam bit PLAY = (gi >= 12) && (gi <= 89) && ((gi % 10) >= 2);
        if (PLAY) begin : g_play
            assign free_vec[gi] = ~bus.body_map[gi];
        end else begin : g_wall
            assign free_vec[gi] = 1'b0;
        end
    end

    assign free_ext = {28'b0, free_vec};

    // Indices 128..255 have bit 7 set and are rejected outright.
    logic free_a, free_b, free_scan;
    assign free_a    = ~cand_a_reg[7]   & free_ext[cand_a_reg[6:0]];
    assign free_b    = ~cand_b_reg[7]   & free_ext[cand_b_reg[6:0]];
    assign free_scan = ~scan_idx_reg[7] & free_ext[scan_idx_reg[6:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SAMPLE;
            cand_a_reg     <= '0;
            cand_b_reg     <= '0;
            tries_reg      <= '0;
            scan_idx_reg   <= SCAN_FIRST;
            food_pos_reg   <= '0;
            food_valid_reg <= 1'b0;
            eaten_reg      <= 1'b0;
            score_reg      <= '0;
            board_full_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cand_a_reg     <= cand_a_next;
            cand_b_reg     <= cand_b_next;
            tries_reg      <= tries_next;
            scan_idx_reg   <= scan_idx_next;
            food_pos_reg   <= food_pos_next;
            food_valid_reg <= food_valid_next;
            eaten_reg      <= eaten_next;
            score_reg      <= score_next;
            board_full_reg <= board_full_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cand_a_next     = cand_a_reg;
        cand_b_next     = cand_b_reg;
        tries_next      = tries_reg;
        scan_idx_next   = scan_idx_reg;
        food_pos_next   = food_pos_reg;
        food_valid_next = food_valid_reg;
        eaten_next      = 1'b0;
        score_next      = score_reg;
        board_full_next = board_full_reg;

        unique case (state_reg)
            SAMPLE: begin
                cand_a_next = bus.cand_a;
                cand_b_next = bus.cand_b;
                state_next  = CHECK;
            end

            CHECK: begin
                if (free_a) begin
                    food_pos_next   = cand_a_reg;
                    food_valid_next = 1'b1;
                    tries_next      = '0;
                    state_next      = HOLD;
                end else if (free_b) begin
                    food_pos_next   = cand_b_reg;
                    food_valid_next = 1'b1;
                    tries_next      = '0;
                    state_next      = HOLD;
                end else if (tries_reg == TRIES_LAST) begin
                    tries_next    = '0;
                    scan_idx_next = SCAN_FIRST;
                    state_next    = SCAN;
                end else begin
                    tries_next = tries_reg + 8'd1;
                    state_next = SAMPLE;
                end
            end

            SCAN: begin
                if (free_scan) begin
                    food_pos_next   = scan_idx_reg;
                    food_valid_next = 1'b1;
                    state_next      = HOLD;
                end else if (scan_idx_reg == SCAN_LAST) begin
                    board_full_next = 1'b1;
                    state_next      = FULL;
                end else begin
                    scan_idx_next = scan_idx_reg + 8'd1;
                end
            end

            HOLD: begin
                // Only a real move onto the food counts; a stationary head over it does not.
                if (bus.move_tick && (bus.head_pos == food_pos_reg)) begin
                    eaten_next      = 1'b1;
                    food_valid_next = 1'b0;
                    if (score_reg != {SCORE_W{1'b1}}) begin
                        score_next = score_reg + 1'b1;
                    end
                    state_next = SAMPLE;
                end
            end

            FULL: begin
                food_valid_next = 1'b0;
                board_full_next = 1'b1;
            end

            default: begin
                state_next = SAMPLE;
            end
        endcase
    end

    assign bus.food_pos   = food_pos_reg;
    assign bus.food_valid = food_valid_reg;
    assign bus.eaten      = eaten_reg;
    assign bus.score      = score_reg;
    assign bus.board_full = board_full_reg;

endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
Consumer end of the food-position generator interface in the snake game. It samples the two candidate cell indices each cycle and rejects cells that are off-field or occupied by the snake body. After repeated misses it falls back to a linear scan. It latches the accepted food cell, detects when the snake head eats it, pulses a grow request, keeps the score and requests a new placement.

Parameters:
MAX_TRIES, 16, consecutive rejected candidate pairs before falling back to linear scan (1..255)
SCORE_W, 8, score counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cand_a  input  8  candidate cell index from generator primary output
cand_b  input  8  candidate cell index from generator secondary output
body_map  input  100  occupancy bitmap, bit i = 1 when cell i holds snake body or head
head_pos  input  8  current snake head cell index
move_tick  input  1  one-cycle pulse, snake advanced this cycle
food_pos  output  8  latched food cell index
food_valid  output  1  food_pos holds a placed food cell
eaten  output  1  one-cycle pulse, food consumed (grow request to snake body logic)
score  output  SCORE_W  foods eaten, saturating
board_full  output  1  no free playable cell found, sticky until reset

Behaviour:
- Cell index = 10*row + col on a 10x10 board.
- Playable(x): 12 <= x <= 89 and (x mod 10) >= 2.
- Free(x): Playable(x) and body_map[x] == 0. The body_map index is used only when Playable(x) holds, so an out-of-range x never indexes past bit 99.
- Reset values: food_pos=0, food_valid=0, eaten=0, score=0, board_full=0, try counter=0, scan index=12, state=SAMPLE.
- Reset applied mid-operation (any state) returns to the reset values on the next edge; no partial placement survives.
- States: SAMPLE, CHECK, SCAN, HOLD, FULL.
- SAMPLE: register cand_a and cand_b into internal regs; go to CHECK.
- CHECK: evaluate Free on the registered pair, using body_map as of this cycle.
  - Free(a): food_pos<=a, food_valid<=1, tries<=0, go to HOLD.
  - else Free(b): same, using b.
  - else if tries == MAX_TRIES-1: tries<=0, scan index<=12, go to SCAN.
  - else tries<=tries+1, go to SCAN only as above, otherwise back to SAMPLE.
  - cand_a has priority over cand_b when both are free.
- Placement latency: food_valid rises on the 2nd rising edge after entering SAMPLE, when the first pair contains a free cell.
- SCAN: test one index per cycle.
  - Free(idx): latch it as in CHECK, go to HOLD.
  - else if idx == 89: board_full<=1, go to FULL.
  - else idx<=idx+1.
  - Worst case 78 cycles.
- HOLD: food_valid=1, food_pos stable.
  - When move_tick=1 and head_pos == food_pos, next edge: eaten<=1 for exactly one cycle, score<=score+1 (holds at 2^SCORE_W-1), food_valid<=0, go to SAMPLE.
  - move_tick=0 never triggers eating, even if head_pos matches.
  - Changes to body_map while in HOLD do not relocate the food.
- move_tick in SAMPLE, CHECK, SCAN or FULL is ignored; eaten stays 0.
- FULL: terminal. food_valid=0, board_full=1, outputs frozen until rst.
- Invalid candidates (e.g. 0, 91, 255, x mod 10 in {0,1}) are simply rejected and count as misses. No error output.
- eaten is never asserted in two consecutive cycles.

Test Plan:
- Reset then body_map=0, cand_a=34, cand_b=57 held -> food_pos=34, food_valid=1 two edges after rst release; score=0, eaten=0.
- body_map bit 34 set, cand_a=34, cand_b=57 -> food_pos=57. Then cand_a=10, cand_b=91 -> both rejected, tries increments, no placement.
- In HOLD at food_pos=57: head_pos=57, move_tick=0 -> no eat. move_tick=1 -> eaten one-cycle pulse, score=1, food_valid=0 next edge, new placement follows.
- cand_a=cand_b=11 held for 16 pairs, body_map bits 12..14 set -> SCAN entered, food_pos=15 placed. All 64 playable cells set -> board_full=1, food_valid=0, FULL held.
- SCORE_W=2: eat 5 foods -> score sequence 1,2,3,3,3.
- Assert rst during SCAN at idx=40 -> all outputs return to reset values; placement restarts from SAMPLE with tries=0.
